// File: rtl/key_bitmap_reader.sv
// key_bitmap_reader: unloads a key bitmap snapshot as one ready/valid transfer per set bit, LSB first.
// Define KEY_SCAN_FAST_EN to replace the bit-serial scan with a one-cycle priority-encoder jump.
module key_bitmap_reader #(
  parameter int WIDTH = 64,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [WIDTH-1:0] ptr_bit;
  logic [WIDTH-1:0] rest;
  logic             cur_bit;
  logic             accept;

`ifdef KEY_SCAN_FAST_EN
  function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
    lowest_set = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction
`endif

  // Bits still pending once the current index has been handed off.
  assign ptr_bit = WIDTH'(1) << ptr_q;
  assign rest    = shadow_q & ~ptr_bit;
  assign cur_bit = |(shadow_q & ptr_bit);

  always_comb begin
    load_ready = (state_q == IDLE) && !reset;
    out_valid  = (state_q == EMIT) && !reset;
    out_index  = out_valid ? ptr_q : '0;
    out_last   = out_valid && (rest == '0);
    busy       = (state_q != IDLE) && !reset;
  end

  assign accept = load_valid && load_ready;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shadow_d = load_data;
          ptr_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (flush) begin
          shadow_d = '0;
          state_d  = IDLE;
        end else if (shadow_q == '0) begin
          state_d = IDLE;
        end else begin
`ifdef KEY_SCAN_FAST_EN
          ptr_d   = lowest_set(shadow_q);
          state_d = EMIT;
`else
          if (cur_bit) state_d = EMIT;
          else         ptr_d   = ptr_q + IDX_W'(1);
`endif
        end
      end
      EMIT: begin
        // Flush drops the presented index even when out_ready is high.
        if (flush) begin
          shadow_d = '0;
          state_d  = IDLE;
        end else if (out_ready) begin
          shadow_d = rest;
          ptr_d    = (ptr_q == IDX_W'(WIDTH - 1)) ? ptr_q : ptr_q + IDX_W'(1);
          state_d  = (rest == '0) ? IDLE : SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule
